// File: rtl/parity_engine_if.sv
// Stream bundle between the parity engine and its neighbours: input word side and result side.
// Pure wiring, no latency of its own.
// Backpressure is carried by InReady (toward upstream) and OutReady (from downstream).
interface parity_engine_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  InValid;
  logic                  InReady;
  logic [DATA_WIDTH-1:0] RegIn;
  logic                  ParityIn;
  logic [1:0]            ParityType;
  logic                  ModeCheck;
  logic                  OutValid;
  logic                  OutReady;
  logic                  ParityOut;
  logic                  ParityErr;

  // Side that feeds words in and consumes results.
  modport master (
    output InValid, RegIn, ParityIn, ParityType, ModeCheck, OutReady,
    input  InReady, OutValid, ParityOut, ParityErr
  );

  // The engine itself.
  modport slave (
    input  InValid, RegIn, ParityIn, ParityType, ModeCheck, OutReady,
    output InReady, OutValid, ParityOut, ParityErr
  );
endinterface

// File: rtl/parity_engine.sv
// UART parity generator/checker with a saturating error counter (compiled in when PARITY_ERRCNT_EN is defined).
// One cycle latency: a word accepted at edge N shows its result after edge N.
// Single-entry result register; InReady = ~OutValid | OutReady, so full throughput while drained.
module parity_engine #(
  parameter int DATA_WIDTH    = 8,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     Clock,
  input  logic                     ResetN,
  parity_engine_if.slave           bus,
  input  logic                     ErrClear,
  output logic [ERR_CNT_WIDTH-1:0] ErrCount
);

  typedef struct packed {
    logic parityErr;
    logic parityOut;
  } resultT;

  logic [DATA_WIDTH-1:0] frame;
  logic                  rawParity;
  logic                  parityEnabled;
  logic                  expParity;
  logic                  inReady;
  logic                  accept;
  logic                  outValidQ;
  resultT                resultD;
  resultT                resultQ;

  assign frame = bus.RegIn;

  // The register only frees up when it is empty or being drained this cycle.
  assign inReady     = ~outValidQ | bus.OutReady;
  assign accept      = bus.InValid & inReady;
  assign bus.InReady = inReady;

  // Expected parity and mismatch for the word currently presented at the input.
  always_comb begin
    rawParity     = ^frame;
    parityEnabled = (bus.ParityType == 2'b01) || (bus.ParityType == 2'b10);
    // Even uses the raw XOR; odd and both no-parity codes output the odd value.
    expParity     = (bus.ParityType == 2'b10) ? rawParity : ~rawParity;
    resultD           = '0;
    resultD.parityOut = expParity;
    resultD.parityErr = bus.ModeCheck & parityEnabled & (bus.ParityIn ^ expParity);
  end

  // Result register: load on accept, clear valid on a drain, otherwise hold.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      outValidQ <= 1'b0;
      resultQ   <= '0;
    end else if (accept) begin
      outValidQ <= 1'b1;
      resultQ   <= resultD;
    end else if (bus.OutReady) begin
      outValidQ <= 1'b0;
    end
  end

  assign bus.OutValid  = outValidQ;
  assign bus.ParityOut = resultQ.parityOut;
  assign bus.ParityErr = resultQ.parityErr;

`ifdef PARITY_ERRCNT_EN
  localparam logic [ERR_CNT_WIDTH-1:0] ErrCntMax = '1;

  logic [ERR_CNT_WIDTH-1:0] errCountQ;

  // Saturating error count; clear wins over a same-edge erroring accept.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      errCountQ <= '0;
    end else if (ErrClear) begin
      errCountQ <= '0;
    end else if (accept && resultD.parityErr && (errCountQ != ErrCntMax)) begin
      errCountQ <= errCountQ + 1'b1;
    end
  end

  assign ErrCount = errCountQ;
`else
  logic unusedErrClear;

  // Counter not built: the clear input has nothing to act on.
  assign unusedErrClear = ErrClear;
  assign ErrCount       = '0;
`endif

endmodule

// File: tb/tb_parity_engine.sv
module tb_parity_engine;
  localparam int DW = 8;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef PARITY_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          ResetN = 1'b0;
  logic          ErrClear = 1'b0;
  logic [CW-1:0] ErrCount;

  parity_engine_if #(.DATA_WIDTH(DW)) bus ();

  parity_engine #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(CW)) dut (
    .Clock   (Clock),
    .ResetN  (ResetN),
    .bus     (bus),
    .ErrClear(ErrClear),
    .ErrCount(ErrCount)
  );

  always #5 Clock = ~Clock;

  int testCount = 0;
  int failCount = 0;
  int gotCount  = 0;

  // Reference state: what the result register and counter should hold.
  bit         mValid = 1'b0;
  bit         mPar   = 1'b0;
  bit         mErr   = 1'b0;
  int         mCnt   = 0;
  logic [1:0] pending[$];

  function automatic bit refParity(logic [1:0] t, logic [DW-1:0] d);
    int ones;
    ones = $countones(d);
    if (t == 2'd2) return (ones % 2) == 1;   // even: bit equals XOR of data
    return (ones % 2) == 0;                  // odd and no-parity codes
  endfunction

  function automatic bit refErr(logic m, logic [1:0] t, logic p, logic [DW-1:0] d);
    if (!m) return 1'b0;
    if (t != 2'd1 && t != 2'd2) return 1'b0;
    return p != refParity(t, d);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic v, logic [1:0] t, logic m, logic [DW-1:0] d, logic p);
    bus.InValid    = v;
    bus.ParityType = t;
    bus.ModeCheck  = m;
    bus.RegIn      = d;
    bus.ParityIn   = p;
  endtask

  task automatic modelReset();
    mValid = 1'b0;
    mPar   = 1'b0;
    mErr   = 1'b0;
    mCnt   = 0;
    pending.delete();
  endtask

  // One clock: check ready and any consumed result, clock, then check registered outputs.
  task automatic cycle();
    bit         rdyExp;
    bit         acc;
    bit         e;
    logic [1:0] head;
    #2;
    rdyExp = !mValid || bus.OutReady;
    check("in_ready", 32'(bus.InReady), 32'(rdyExp));
    acc = ResetN && bus.InValid && rdyExp;
    if (ResetN && mValid && bus.OutReady && pending.size() > 0) begin
      head = pending.pop_front();
      check("consume_par", 32'(bus.ParityOut), 32'(head[0]));
      check("consume_err", 32'(bus.ParityErr), 32'(head[1]));
      gotCount++;
    end
    @(posedge Clock);
    if (!ResetN) begin
      modelReset();
    end else begin
      e = refErr(bus.ModeCheck, bus.ParityType, bus.ParityIn, bus.RegIn);
      if (acc) begin
        mValid = 1'b1;
        mPar   = refParity(bus.ParityType, bus.RegIn);
        mErr   = e;
        pending.push_back({mErr, mPar});
      end else if (bus.OutReady) begin
        mValid = 1'b0;
      end
      if (CNT_EN) begin
        if (ErrClear) mCnt = 0;
        else if (acc && e && mCnt < CNT_MAX) mCnt++;
      end
    end
    #1;
    check("out_valid", 32'(bus.OutValid), 32'(mValid));
    check("parity_out", 32'(bus.ParityOut), 32'(mPar));
    check("parity_err", 32'(bus.ParityErr), 32'(mErr));
    check("err_count", 32'(ErrCount), 32'(mCnt));
  endtask

  initial begin
    int base;
    drive(1'b0, 2'd0, 1'b0, '0, 1'b0);
    bus.OutReady = 1'b1;

    // Reset values with no clock edge seen yet.
    #1;
    check("rst_valid", 32'(bus.OutValid), 32'd0);
    check("rst_par", 32'(bus.ParityOut), 32'd0);
    check("rst_err", 32'(bus.ParityErr), 32'd0);
    check("rst_cnt", 32'(ErrCount), 32'd0);
    check("rst_ready", 32'(bus.InReady), 32'd1);
    @(posedge Clock);
    #1;
    ResetN = 1'b1;

    // Generate mode, odd then even on A5 (four ones).
    drive(1'b1, 2'd1, 1'b0, 8'hA5, 1'b0); cycle();
    check("gen_odd_a5", 32'(bus.ParityOut), 32'd1);
    check("gen_odd_a5_err", 32'(bus.ParityErr), 32'd0);
    drive(1'b1, 2'd2, 1'b0, 8'hA5, 1'b0); cycle();
    check("gen_even_a5", 32'(bus.ParityOut), 32'd0);

    // Check mode on 07 (three ones), even parity.
    drive(1'b1, 2'd2, 1'b1, 8'h07, 1'b0); cycle();
    check("chk_bad_err", 32'(bus.ParityErr), 32'd1);
    check("chk_bad_cnt", 32'(ErrCount), CNT_EN ? 32'd1 : 32'd0);
    drive(1'b1, 2'd2, 1'b1, 8'h07, 1'b1); cycle();
    check("chk_good_err", 32'(bus.ParityErr), 32'd0);
    check("chk_good_cnt", 32'(ErrCount), CNT_EN ? 32'd1 : 32'd0);

    // No-parity codes never flag.
    drive(1'b1, 2'd0, 1'b1, 8'h01, 1'b1); cycle();
    check("nopar00_out", 32'(bus.ParityOut), 32'd0);
    check("nopar00_err", 32'(bus.ParityErr), 32'd0);
    drive(1'b1, 2'd3, 1'b1, 8'h01, 1'b1); cycle();
    check("nopar11_out", 32'(bus.ParityOut), 32'd0);
    check("nopar11_err", 32'(bus.ParityErr), 32'd0);
    drive(1'b0, 2'd0, 1'b0, '0, 1'b0); cycle();

    // Backpressure: first result held 3 cycles while the next word waits.
    base = gotCount;
    drive(1'b1, 2'd1, 1'b0, 8'hA5, 1'b0); cycle();
    bus.OutReady = 1'b0;
    drive(1'b1, 2'd2, 1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus.ParityType = 2'(i);
      cycle();
      check("stall_ready", 32'(bus.InReady), 32'd0);
      check("stall_par", 32'(bus.ParityOut), 32'd1);
      check("stall_valid", 32'(bus.OutValid), 32'd1);
    end
    bus.OutReady = 1'b1;
    drive(1'b1, 2'd2, 1'b1, 8'h3C, 1'b1); cycle();
    drive(1'b1, 2'd1, 1'b1, 8'h80, 1'b1); cycle();
    drive(1'b1, 2'd2, 1'b0, 8'hFF, 1'b0); cycle();
    drive(1'b0, 2'd0, 1'b0, '0, 1'b0); cycle();
    check("bp_count", 32'(gotCount - base), 32'd4);

    // Saturation and clear priority.
    ErrClear = 1'b1; cycle(); ErrClear = 1'b0;
    check("clear_cnt", 32'(ErrCount), 32'd0);
    drive(1'b1, 2'd2, 1'b1, 8'h07, 1'b0);
    for (int i = 0; i < 5; i++) cycle();
    check("sat_cnt", 32'(ErrCount), CNT_EN ? 32'd3 : 32'd0);
    ErrClear = 1'b1; cycle(); ErrClear = 1'b0;
    check("clr_err_cnt", 32'(ErrCount), 32'd0);
    check("clr_err_flag", 32'(bus.ParityErr), 32'd1);

    // Async reset between edges with a held result and count of two.
    cycle(); cycle();
    bus.OutReady = 1'b0;
    drive(1'b0, 2'd0, 1'b0, '0, 1'b0); cycle();
    check("pre_rst_cnt", 32'(ErrCount), CNT_EN ? 32'd2 : 32'd0);
    check("pre_rst_valid", 32'(bus.OutValid), 32'd1);
    #3;
    ResetN = 1'b0;
    #1;
    modelReset();
    check("arst_valid", 32'(bus.OutValid), 32'd0);
    check("arst_par", 32'(bus.ParityOut), 32'd0);
    check("arst_err", 32'(bus.ParityErr), 32'd0);
    check("arst_cnt", 32'(ErrCount), 32'd0);
    check("arst_ready", 32'(bus.InReady), 32'd1);
    drive(1'b1, 2'd2, 1'b1, 8'h07, 1'b0); cycle();
    check("in_rst_no_accept", 32'(bus.OutValid), 32'd0);
    ResetN = 1'b1;
    bus.OutReady = 1'b1;
    cycle();
    check("first_accept", 32'(bus.OutValid), 32'd1);

    // Randomized traffic against the reference.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(3) != 0), 2'($urandom), 1'($urandom), DW'($urandom), 1'($urandom));
      bus.OutReady = 1'($urandom_range(3) != 0);
      ErrClear     = ($urandom_range(15) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
